// File: rtl/control_pkg.sv
// Shared definitions for the SAP-style microcode sequencer.
//   - opcode constants (upper nibble of the instruction register)
//   - control word bit positions and single-bit masks
//   - ALU flag bit positions
package control_pkg;

   localparam int CTRL_W = 16;

   typedef logic [CTRL_W-1:0] ctrl_t;

   // Control word bit positions
   localparam int CTRL_HLT = 15;
   localparam int CTRL_MI  = 14;
   localparam int CTRL_RI  = 13;
   localparam int CTRL_RO  = 12;
   localparam int CTRL_IO  = 11;
   localparam int CTRL_II  = 10;
   localparam int CTRL_AI  = 9;
   localparam int CTRL_AO  = 8;
   localparam int CTRL_EO  = 7;
   localparam int CTRL_SU  = 6;
   localparam int CTRL_BI  = 5;
   localparam int CTRL_OI  = 4;
   localparam int CTRL_CE  = 3;
   localparam int CTRL_CO  = 2;
   localparam int CTRL_J   = 1;
   localparam int CTRL_FI  = 0;

   // Single-bit masks, OR-ed together to build microwords
   localparam ctrl_t C_HLT = ctrl_t'(1 << CTRL_HLT);
   localparam ctrl_t C_MI  = ctrl_t'(1 << CTRL_MI);
   localparam ctrl_t C_RI  = ctrl_t'(1 << CTRL_RI);
   localparam ctrl_t C_RO  = ctrl_t'(1 << CTRL_RO);
   localparam ctrl_t C_IO  = ctrl_t'(1 << CTRL_IO);
   localparam ctrl_t C_II  = ctrl_t'(1 << CTRL_II);
   localparam ctrl_t C_AI  = ctrl_t'(1 << CTRL_AI);
   localparam ctrl_t C_AO  = ctrl_t'(1 << CTRL_AO);
   localparam ctrl_t C_EO  = ctrl_t'(1 << CTRL_EO);
   localparam ctrl_t C_SU  = ctrl_t'(1 << CTRL_SU);
   localparam ctrl_t C_BI  = ctrl_t'(1 << CTRL_BI);
   localparam ctrl_t C_OI  = ctrl_t'(1 << CTRL_OI);
   localparam ctrl_t C_CE  = ctrl_t'(1 << CTRL_CE);
   localparam ctrl_t C_CO  = ctrl_t'(1 << CTRL_CO);
   localparam ctrl_t C_J   = ctrl_t'(1 << CTRL_J);
   localparam ctrl_t C_FI  = ctrl_t'(1 << CTRL_FI);

   // Opcodes; 1001..1101 are unassigned and behave as NOP
   localparam logic [3:0] OP_NOP = 4'b0000;
   localparam logic [3:0] OP_LDA = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0011;
   localparam logic [3:0] OP_STA = 4'b0100;
   localparam logic [3:0] OP_LDI = 4'b0101;
   localparam logic [3:0] OP_JMP = 4'b0110;
   localparam logic [3:0] OP_JC  = 4'b0111;
   localparam logic [3:0] OP_JZ  = 4'b1000;
   localparam logic [3:0] OP_OUT = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   // ALU flags register bit positions
   localparam int FLAG_C = 1;
   localparam int FLAG_Z = 0;

endpackage

// File: rtl/control_sequencer_if.sv
// Signal bundle between the sequencer and the rest of the CPU.
//   slave  : sequencer view (consumes opcode/flags/step_en, drives control)
//   master : CPU / environment view (the mirror image)
interface control_sequencer_if;
   import control_pkg::*;

   logic [3:0] opcode;            // IR upper nibble
   logic [1:0] flag_out;          // ALU flags: [1]=carry, [0]=zero
   logic       step_en;           // advance enable
   ctrl_t      ctrl;              // active-high control word
   logic       alu_bus_enable_n;  // ~ctrl[EO]
   logic       alu_subtract;      // ctrl[SU]
   logic       flag_fi_n;         // ~ctrl[FI]
   logic [2:0] step;              // current T-state
   logic       halted;            // HLT executed

   modport slave (
      input  opcode, flag_out, step_en,
      output ctrl, alu_bus_enable_n, alu_subtract, flag_fi_n, step, halted
   );

   modport master (
      output opcode, flag_out, step_en,
      input  ctrl, alu_bus_enable_n, alu_subtract, flag_fi_n, step, halted
   );
endinterface

// File: rtl/control_sequencer_microcode_rom.sv
// Combinational microcode ROM.
//   opcode : instruction opcode
//   step   : current T-state
//   flags  : ALU flags, used to resolve JC/JZ at T2
//   word   : control word for this (opcode, step, flags); 0 for unused slots
module microcode_rom
   import control_pkg::*;
(
   input  logic [3:0] opcode,
   input  logic [2:0] step,
   input  logic [1:0] flags,
   output ctrl_t      word
);

   always_comb begin
      word = '0;
      case (step)
         3'd0: word = C_CO | C_MI;
         3'd1: word = C_RO | C_II | C_CE;
         default: begin
            case (opcode)
               OP_LDA: case (step)
                  3'd2:    word = C_IO | C_MI;
                  3'd3:    word = C_RO | C_AI;
                  default: word = '0;
               endcase
               OP_ADD: case (step)
                  3'd2:    word = C_IO | C_MI;
                  3'd3:    word = C_RO | C_BI;
                  3'd4:    word = C_EO | C_AI | C_FI;
                  default: word = '0;
               endcase
               OP_SUB: case (step)
                  3'd2:    word = C_IO | C_MI;
                  3'd3:    word = C_RO | C_BI;
                  3'd4:    word = C_EO | C_AI | C_SU | C_FI;
                  default: word = '0;
               endcase
               OP_STA: case (step)
                  3'd2:    word = C_IO | C_MI;
                  3'd3:    word = C_AO | C_RI;
                  default: word = '0;
               endcase
               OP_LDI:  word = (step == 3'd2) ? (C_IO | C_AI) : '0;
               OP_JMP:  word = (step == 3'd2) ? (C_IO | C_J) : '0;
               // Untaken conditional jumps decode to 0, which lets early-end
               // retire them right after T2.
               OP_JC:   word = (step == 3'd2 && flags[FLAG_C]) ? (C_IO | C_J) : '0;
               OP_JZ:   word = (step == 3'd2 && flags[FLAG_Z]) ? (C_IO | C_J) : '0;
               OP_OUT:  word = (step == 3'd2) ? (C_AO | C_OI) : '0;
               OP_HLT:  word = (step == 3'd2) ? C_HLT : '0;
               default: word = '0;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Microcode sequencer: T-state counter, early instruction end, halt latch,
// and ALU pin polarity mapping around the microcode ROM.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : opcode/flag_out/step_en in; ctrl, ALU pins, step, halted out
module control_sequencer
   import control_pkg::*;
#(
   parameter int NUM_STEPS = 5,
   parameter bit EARLY_END = 1'b1
) (
   input logic              clk,
   input logic              rst,
   control_sequencer_if.slave bus
);

   localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);

   logic [2:0] step;
   logic       halted;
   ctrl_t      word;

   microcode_rom u_rom (
      .opcode (bus.opcode),
      .step   (step),
      .flags  (bus.flag_out),
      .word   (word)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step   <= '0;
         halted <= 1'b0;
      end else if (bus.step_en && !halted) begin
         if (word[CTRL_HLT])
            halted <= 1'b1;              // step freezes on the HLT slot
         else if (step == LAST_STEP)
            step <= '0;
         else if (EARLY_END && step >= 3'd2 && word == '0)
            step <= '0;
         else
            step <= step + 3'd1;
      end
   end

   // Once halted, only the HLT bit survives regardless of the ROM slot.
   always_comb begin
      bus.ctrl = halted ? C_HLT : word;
   end

   assign bus.alu_bus_enable_n = ~bus.ctrl[CTRL_EO];
   assign bus.alu_subtract     = bus.ctrl[CTRL_SU];
   assign bus.flag_fi_n        = ~bus.ctrl[CTRL_FI];
   assign bus.step             = step;
   assign bus.halted           = halted;

endmodule
